// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and width helper for the FIFO drain arbiter
package fifo_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) is 0, matching the FIFO's pointer sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular priority encoder
module rr_pick
  import fifo_drain_pkg::*;
#(
  parameter int NumPorts = 4,
  localparam int PortWidth = clog2(NumPorts)
) (
  input  logic [NumPorts-1:0]  Req,
  input  logic [PortWidth-1:0] Last,
  output logic                 Found,
  output logic [PortWidth-1:0] Index
);

  logic [PortWidth-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest request after Last wins.
  always_comb begin
    Found = 1'b0;
    Index = '0;
    cand  = '0;
    for (int i = NumPorts; i >= 1; i--) begin
      cand = PortWidth'((int'(Last) + i) % NumPorts);
      if (Req[cand]) begin
        Found = 1'b1;
        Index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - bounded-burst round-robin drain of show-ahead FIFOs into one stream
module fifo_drain_arbiter
  import fifo_drain_pkg::*;
#(
  parameter int NumPorts  = 4,
  parameter int DataWidth = 32,
  parameter int BurstLen  = 4,
  localparam int PortWidth = clog2(NumPorts)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NumPorts-1:0]           NotEmpty,
  input  logic [NumPorts*DataWidth-1:0] ReadData,
  output logic [NumPorts-1:0]           Read,
  output logic [DataWidth-1:0]          OutData,
  output logic [PortWidth-1:0]          OutPort,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic                          Busy
);

  localparam int CntWidth = clog2(BurstLen + 1);

  state_t               state;
  logic [PortWidth-1:0] grant;
  logic [PortWidth-1:0] last_grant;
  logic [CntWidth-1:0]  burst_cnt;

  logic                 pick_found;
  logic [PortWidth-1:0] pick_index;
  logic                 slot;
  logic                 grant_ne;
  logic                 pop;
  logic                 burst_last;
  logic [DataWidth-1:0] sel_data;

  rr_pick #(
    .NumPorts(NumPorts)
  ) u_pick (
    .Req  (NotEmpty),
    .Last (last_grant),
    .Found(pick_found),
    .Index(pick_index)
  );

  // Pop decision: only when the output register can take a word and the granted FIFO has one.
  always_comb begin
    slot       = ~OutValid | OutReady;
    grant_ne   = NotEmpty[grant];
    pop        = (state == SERVE) & slot & grant_ne & ~Reset;
    burst_last = (burst_cnt == CntWidth'(BurstLen - 1));
    Read       = pop ? (NumPorts'(1) << grant) : '0;
  end

  // Select the granted FIFO's show-ahead word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (grant == PortWidth'(i)) sel_data = ReadData[i*DataWidth +: DataWidth];
    end
  end

  assign Busy = (state == SERVE);

  // Arbitration FSM, burst counter and output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PortWidth'(NumPorts - 1);
      burst_cnt  <= '0;
      OutValid   <= 1'b0;
      OutData    <= '0;
      OutPort    <= '0;
    end else begin
      if (OutValid && OutReady) OutValid <= 1'b0;
      if (pop) begin
        OutData   <= sel_data;
        OutPort   <= grant;
        OutValid  <= 1'b1;
        burst_cnt <= burst_cnt + CntWidth'(1);
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant      <= pick_index;
            last_grant <= pick_index;
            burst_cnt  <= '0;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if ((pop && burst_last) || !grant_ne) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - scoreboard bench for fifo_drain_arbiter
module tb_fifo_drain_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int BL = 4;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
  } exp_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NP-1:0]     NotEmpty;
  logic [NP*DW-1:0]  ReadData;
  logic [NP-1:0]     Read;
  logic [DW-1:0]     OutData;
  logic [1:0]        OutPort;
  logic              OutValid;
  logic              OutReady;
  logic              Busy;

  logic [DW-1:0] fq [NP][$];
  exp_t          exp_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            rd1_cnt = 0;
  int            stall_cnt = 0;
  int            word_cnt = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic [1:0]    held_p;
  logic [NP-1:0] rd_s;

  always #5 Clk = ~Clk;

  fifo_drain_arbiter #(
    .NumPorts(NP),
    .DataWidth(DW),
    .BurstLen(BL)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .NotEmpty(NotEmpty),
    .ReadData(ReadData),
    .Read(Read),
    .OutData(OutData),
    .OutPort(OutPort),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Busy(Busy)
  );

  function automatic logic [DW-1:0] word(input int p, input int k);
    return 32'hA000_0000 | DW'(p << 16) | DW'(k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input int p, input int k);
    exp_t x;
    x.port = 2'(p);
    x.data = word(p, k);
    exp_q.push_back(x);
  endtask

  task automatic load(input int p, input int n);
    for (int k = 0; k < n; k++) fq[p].push_back(word(p, k));
  endtask

  function automatic void refresh();
    for (int i = 0; i < NP; i++) begin
      NotEmpty[i] = (fq[i].size() != 0);
      ReadData[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endfunction

  // Show-ahead FIFO models: pop on the Read seen mid-cycle, present the new head after the edge.
  initial begin
    refresh();
    forever begin
      @(negedge Clk);
      rd_s = Read;
      @(posedge Clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (rd_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      refresh();
    end
  end

  // Monitor: protocol checks and scoreboard comparison on every accepted word.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Read != '0) begin
        chk("read_onehot", 64'($onehot(Read)), 64'd1);
        chk("read_when_empty", 64'(Read & ~NotEmpty), 64'd0);
      end
      if (Read[1]) rd1_cnt++;
      if (held_v) begin
        chk("stall_data_stable", 64'(OutData), 64'(held_d));
        chk("stall_port_stable", 64'(OutPort), 64'(held_p));
      end
      if (OutValid && !OutReady) begin
        chk("stall_no_read", 64'(Read), 64'd0);
        stall_cnt++;
        held_v = 1'b1;
        held_d = OutData;
        held_p = OutPort;
      end else begin
        held_v = 1'b0;
      end
      if (OutValid && OutReady) begin
        word_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0d:%0h required=none", OutPort, OutData);
        end else begin
          e = exp_q.pop_front();
          chk("out_port", 64'(OutPort), 64'(e.port));
          chk("out_data", 64'(OutData), 64'(e.data));
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !Busy && !OutValid && NotEmpty == '0) done = 1'b1;
    end
    chk(name, 64'(done), 64'd1);
    chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Loads queued words so they become visible at the start of the next cycle (cycle 0).
  task automatic start_cycle0();
    @(posedge Clk);
    #2;
  endtask

  int t_rd [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int t_bz [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int t_ov [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  int bp   [8]  = '{1, 1, 1, 0, 0, 1, 1, 1};

  initial begin
    Reset    = 1'b1;
    OutReady = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("read_in_reset", 64'(Read), 64'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_outdata", 64'(OutData), 64'd0);
    chk("rst_outport", 64'(OutPort), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_read", 64'(Read), 64'd0);

    // Single port burst: port 2 with six words, cycle-exact pattern.
    load(2, 6);
    for (int k = 0; k < 6; k++) expect_word(2, k);
    start_cycle0();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      chk($sformatf("burst_read_c%0d", c), 64'(Read), t_rd[c] != 0 ? 64'h4 : 64'h0);
      chk($sformatf("burst_busy_c%0d", c), 64'(Busy), 64'(t_bz[c]));
      chk($sformatf("burst_ovalid_c%0d", c), 64'(OutValid), 64'(t_ov[c]));
    end
    wait_drain("single_drain", 50);

    // Back-pressure: port 0 next after port 2; ready drops for two cycles mid-burst.
    stall_cnt = 0;
    @(negedge Clk);
    load(0, 4);
    for (int k = 0; k < 4; k++) expect_word(0, k);
    start_cycle0();
    for (int c = 0; c < 8; c++) begin
      OutReady = bp[c] != 0;
      @(posedge Clk);
      #2;
    end
    OutReady = 1'b1;
    wait_drain("bp_drain", 50);
    chk("bp_stall_cycles", 64'(stall_cnt), 64'd2);

    // Empty mid-burst: port 1 runs dry after two words, port 3 follows.
    rd1_cnt = 0;
    @(negedge Clk);
    load(1, 2);
    load(3, 2);
    expect_word(1, 0);
    expect_word(1, 1);
    expect_word(3, 0);
    expect_word(3, 1);
    start_cycle0();
    wait_drain("empty_drain", 50);
    chk("empty_read1_pulses", 64'(rd1_cnt), 64'd2);

    // Fairness: every port full, strict rotation starting at port 0.
    word_cnt = 0;
    @(negedge Clk);
    for (int p = 0; p < NP; p++) load(p, 8);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < BL; k++) expect_word(p, r * BL + k);
    start_cycle0();
    wait_drain("fair_drain", 200);
    chk("fair_word_count", 64'(word_cnt), 64'd32);

    // Reset mid-burst: discard pending word, restart with port 0 priority.
    @(negedge Clk);
    load(0, 4);
    load(2, 2);
    expect_word(0, 0);
    start_cycle0();
    begin
      int cnt;
      logic hit;
      cnt = 0;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge Clk);
        if (Read[0]) cnt++;
        if (cnt == 2) hit = 1'b1;
      end
      chk("rst_mid_second_pop_seen", 64'(hit), 64'd1);
    end
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_pending_valid", 64'(OutValid), 64'd1);
    chk("rst_mid_read_in_reset", 64'(Read), 64'd0);
    expect_word(0, 2);
    expect_word(0, 3);
    expect_word(2, 0);
    expect_word(2, 1);
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_outvalid", 64'(OutValid), 64'd0);
    chk("rst_mid_read", 64'(Read), 64'd0);
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    wait_drain("rst_mid_drain", 50);

    // Idle: nothing to serve for twenty cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      chk("idle_outputs", {61'd0, Busy, OutValid, |Read}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin read-side scheduler that drains several show-ahead FIFOs into one output stream. It sits behind a bank of ASYNCFIFO instances, all with ShowHead=1, on their common read clock. It owns each FIFO's Read strobe and merges the popped words into a single valid/ready stream tagged with the source port. Grants are bounded-burst so that no FIFO can starve the others.

## Interface
Parameters:
- NumPorts, 4 — number of FIFOs served, ≥2.
- DataWidth, 32 — word width; must match the FIFOs.
- BurstLen, 4 — maximum words popped per grant, ≥1.
- PortWidth, derived localparam — clog2(NumPorts), the width of OutPort.

Ports:
- Clk  in  1  — single clock, the FIFOs' ReadClk.
- Reset  in  1  — synchronous, active-high.
- NotEmpty  in  NumPorts  — per-FIFO NotEmpty.
- ReadData  in  NumPorts*DataWidth  — port i occupies bits [i*DataWidth +: DataWidth]; show-ahead data, valid while NotEmpty[i].
- Read  out  NumPorts  — per-FIFO pop strobe, at most one bit set.
- OutData  out  DataWidth  — registered output word.
- OutPort  out  PortWidth  — source index of OutData.
- OutValid  out  1  — OutData/OutPort valid.
- OutReady  in  1  — consumer accepts the word when OutValid&OutReady.
- Busy  out  1  — high in SERVE state.

## Operation
- FSM states: IDLE and SERVE.
- **IDLE**
  - If any NotEmpty is set, pick the first set port searching upward, circularly, from LastGrant+1.
  - Register that port as Grant and as LastGrant, clear BurstCnt, and go to SERVE.
  - Otherwise stay in IDLE.
- **SERVE**
  - Define Slot = ~OutValid | OutReady.
  - Pop = Slot & NotEmpty[Grant]. Read[Grant] = Pop; all other Read bits are 0.
  - On Pop: OutData←ReadData slice of Grant, OutPort←Grant, OutValid←1, BurstCnt←BurstCnt+1.
  - Exit to IDLE when, in the same cycle, (Pop & BurstCnt==BurstLen-1) or ~NotEmpty[Grant].
  - If Slot=0 and NotEmpty[Grant]=1, hold: no pop and no exit.
- **Output register**
  - On OutValid&OutReady with no Pop, OutValid←0.
  - When Pop coincides with OutReady, the register is replaced with no bubble.
  - OutData and OutPort are stable while OutValid&~OutReady.
- Read is combinational from the registered state, NotEmpty and OutReady. It is never asserted when the corresponding NotEmpty=0, which protects the FIFO pointers.
- BurstCnt width is clog2(BurstLen+1) and it never wraps.
- LastGrant wraps from NumPorts-1 to 0.

## Timing
- **Reset values:**
  - State=IDLE, LastGrant=NumPorts-1, so port 0 has first priority.
  - BurstCnt=0.
  - OutValid=0, OutData=0, OutPort=0.
  - Busy=0, Read=0.
  - Read is also 0 during every cycle that Reset is high.
- **Latency:** NotEmpty rising in cycle 0 (IDLE) → grant at the cycle-0 edge → Read pulse in cycle 1 → OutValid=1 in cycle 2.
- **Steady-state throughput:**
  - BurstLen words per BurstLen+1 cycles; one IDLE re-arbitration cycle per grant.
  - This holds even when only one port is requesting (it is re-granted to itself).
- **Back-pressure:** OutReady=0 with OutValid=1 holds SERVE with Read=0. Popping resumes in the same cycle OutReady returns to 1.
- **Empty mid-burst:** NotEmpty[Grant] falling causes exit with no pop that cycle. The partial burst counts as that port's turn.
- **Reset mid-burst:**
  - The next cycle is in reset state and any pending OutValid word is discarded.
  - FIFO contents are untouched.
- **Simultaneous requests:** the rotation is strictly fair. With all ports always non-empty, the service order is 0,1,2,3,0,…

## Structure
- Package fifo_drain_pkg holds:
  - the state enum (IDLE, SERVE);
  - the clog2 function, with the same semantics as the FIFO's;
  - nothing DataWidth-dependent.
- Sub-module rr_pick: combinational circular priority encoder.
  - Inputs: Req[NumPorts], Last[PortWidth].
  - Outputs: Found, Index.
  - It is reused by later multi-requester blocks.
- The top level holds the FSM, burst counter, output register and the ReadData slice mux.

## Test plan
- **Single port burst:** port 2 holds 6 words (A0–A5), OutReady=1 held → Read[2] pulses in cycles 1–4, IDLE in cycle 5, then pops A4 and A5. Output is A0..A5 with OutPort=2 and a one-cycle OutValid gap after A3.
- **Fairness:** all 4 ports hold 8 words, OutReady=1 → OutPort sequence is 0×4, 1×4, 2×4, 3×4, 0×4, …; no Read overlap; 32 words total.
- **Back-pressure:** OutReady toggles 1,0,0,1 during a burst → OutData is stable while OutReady=0, no Read during the stall, no word lost or duplicated.
- **Empty mid-burst:** port 1 holds 2 words with BurstLen=4 → exactly 2 Read[1] pulses, then IDLE. Port 3 (non-empty) is granted next and Read[1] never fires while NotEmpty[1]=0.
- **Reset mid-burst:** assert Reset after the 2nd pop of port 0 with OutValid=1 → the next cycle has OutValid=0, Read=0, Busy=0. The first grant after release goes to port 0 if non-empty.
- **Idle behaviour:** NotEmpty=0 for 20 cycles → Read=0, OutValid=0 and Busy=0 throughout.
